// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment pattern constants (gfedcba order) and decoder result codes
package seg7_pkg;
  localparam logic [6:0] SEG7_P0 = 7'h3F;
  localparam logic [6:0] SEG7_P1 = 7'h06;
  localparam logic [6:0] SEG7_P2 = 7'h5B;
  localparam logic [6:0] SEG7_P3 = 7'h4F;
  localparam logic [6:0] SEG7_P4 = 7'h66;
  localparam logic [6:0] SEG7_P5 = 7'h6D;
  localparam logic [6:0] SEG7_P6 = 7'h7D;
  localparam logic [6:0] SEG7_P7 = 7'h07;
  localparam logic [6:0] SEG7_P8 = 7'h7F;
  localparam logic [6:0] SEG7_P9 = 7'h6F;
  localparam logic [6:0] SEG7_POFF = 7'h00;
  localparam logic [3:0] SEG7_BLANK = 4'hF;
  localparam logic [3:0] SEG7_INVALID = 4'hE;
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational gfedcba pattern to BCD nibble, blank code or invalid code with error flag
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] nib,
  output logic       inv
);
  // Any pattern that is neither a digit nor all-dark is reported invalid
  always_comb begin
    nib = pat == SEG7_P0 ? 4'd0 :
          pat == SEG7_P1 ? 4'd1 :
          pat == SEG7_P2 ? 4'd2 :
          pat == SEG7_P3 ? 4'd3 :
          pat == SEG7_P4 ? 4'd4 :
          pat == SEG7_P5 ? 4'd5 :
          pat == SEG7_P6 ? 4'd6 :
          pat == SEG7_P7 ? 4'd7 :
          pat == SEG7_P8 ? 4'd8 :
          pat == SEG7_P9 ? 4'd9 :
          pat == SEG7_POFF ? SEG7_BLANK : SEG7_INVALID;
    inv = nib == SEG7_INVALID;
  end
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers BCD digits from a scanned 7-segment bus into atomic frames; SEG7_DP_CAPTURE_EN adds decimal-point capture
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     err,
  output logic                  frame_stb,
`ifdef SEG7_DP_CAPTURE_EN
  output logic [DIGITS-1:0]     dp_out,
`endif
  output logic                  frame_valid
);
  localparam int CW = $clog2(STABLE_CNT + 1);
`ifdef SEG7_DP_CAPTURE_EN
  localparam int KW = 8;
`else
  localparam int KW = 7;
  logic unused_dp;
  assign unused_dp = seg_in[7];
`endif
  logic [KW-1:0]         s_seg_q, s_seg_d;
  logic [DIGITS-1:0]     s_sel_q, s_sel_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DIGITS-1:0]     mask_q, mask_d;
  logic [4*DIGITS-1:0]   sh_bcd_q, sh_bcd_d, bcd_q, bcd_d;
  logic [DIGITS-1:0]     sh_err_q, sh_err_d, err_q, err_d;
  logic                  stb_q, stb_d, valid_q, valid_d;
  logic                  onehot, match, commit, frame;
  logic [3:0]            dec_nib;
  logic                  dec_err;
`ifdef SEG7_DP_CAPTURE_EN
  logic [DIGITS-1:0]     sh_dp_q, sh_dp_d, dp_q, dp_d;
`endif

  seg7_pattern_decode u_dec (
    .pat (seg_in[6:0]),
    .nib (dec_nib),
    .inv (dec_err)
  );

  // Stability qualification: count identical one-hot samples and commit once per dwell
  always_comb begin
    s_seg_d = seg_in[KW-1:0];
    s_sel_d = dig_sel;
    onehot  = $onehot(dig_sel);
    match   = onehot && dig_sel == s_sel_q && seg_in[KW-1:0] == s_seg_q;
    commit  = match && cnt_q == CW'(STABLE_CNT - 1);
    cnt_d   = match ? (cnt_q == CW'(STABLE_CNT) ? cnt_q : cnt_q + CW'(1)) : CW'(onehot);
  end

  // Shadow and mask update; publish the whole frame once every digit has committed
  always_comb begin
    sh_bcd_d = sh_bcd_q;
    sh_err_d = sh_err_q;
    mask_d   = mask_q;
`ifdef SEG7_DP_CAPTURE_EN
    sh_dp_d  = sh_dp_q;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (commit && dig_sel[i]) begin
        sh_bcd_d[4*i +: 4] = dec_nib;
        sh_err_d[i]        = dec_err;
        mask_d[i]          = 1'b1;
`ifdef SEG7_DP_CAPTURE_EN
        sh_dp_d[i]         = seg_in[7];
`endif
      end
    end
    frame   = &mask_d;
    mask_d  = frame ? '0 : mask_d;
    bcd_d   = frame ? sh_bcd_d : bcd_q;
    err_d   = frame ? sh_err_d : err_q;
    stb_d   = frame;
    valid_d = valid_q | frame;
`ifdef SEG7_DP_CAPTURE_EN
    dp_d    = frame ? sh_dp_d : dp_q;
`endif
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg_q  <= '0;
      s_sel_q  <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      sh_bcd_q <= '0;
      sh_err_q <= '0;
      bcd_q    <= {DIGITS{SEG7_BLANK}};
      err_q    <= '0;
      stb_q    <= 1'b0;
      valid_q  <= 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
      sh_dp_q  <= '0;
      dp_q     <= '0;
`endif
    end else begin
      s_seg_q  <= s_seg_d;
      s_sel_q  <= s_sel_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      sh_bcd_q <= sh_bcd_d;
      sh_err_q <= sh_err_d;
      bcd_q    <= bcd_d;
      err_q    <= err_d;
      stb_q    <= stb_d;
      valid_q  <= valid_d;
`ifdef SEG7_DP_CAPTURE_EN
      sh_dp_q  <= sh_dp_d;
      dp_q     <= dp_d;
`endif
    end
  end

  assign bcd_out     = bcd_q;
  assign err         = err_q;
  assign frame_stb   = stb_q;
  assign frame_valid = valid_q;
`ifdef SEG7_DP_CAPTURE_EN
  assign dp_out      = dp_q;
`endif
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed scans checked against a run-length frame model plus literal frame values
module tb_seg7_scan_decoder;
  localparam int STABLE = 3;
  logic        clk = 0;
  logic        rst;
  logic [7:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] bcd_out;
  logic [3:0]  err;
  logic        frame_stb, frame_valid;
`ifdef SEG7_DP_CAPTURE_EN
  logic [3:0]  dp_out;
`endif
  int total = 0, bad = 0, stbs = 0, base;
  bit started = 0;

  seg7_scan_decoder #(.DIGITS(4), .STABLE_CNT(STABLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .bcd_out     (bcd_out),
    .err         (err),
    .frame_stb   (frame_stb),
`ifdef SEG7_DP_CAPTURE_EN
    .dp_out      (dp_out),
`endif
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask

  logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [3:0] dec(input logic [6:0] p);
    if (p == 7'h00) return 4'hF;
    for (int i = 0; i < 10; i++) if (p == pats[i]) return 4'(i);
    return 4'hE;
  endfunction

  // Model: a digit commits when its run of identical one-hot samples reaches exactly STABLE
  logic [15:0] m_sh, m_bcd;
  logic [3:0]  m_sh_err, m_err, m_mask, m_sh_dp, m_dp;
  logic        m_stb, m_valid;
  logic [3:0]  p_sel;
  logic [7:0]  p_seg;
  int          run;
  always @(posedge clk) begin
    started <= 1;
    if (rst) begin
      m_sh = 0; m_sh_err = 0; m_sh_dp = 0; m_mask = 0;
      m_bcd = 16'hFFFF; m_err = 0; m_dp = 0; m_stb = 0; m_valid = 0;
      run = 0; p_sel = 0; p_seg = 0;
    end else begin
      logic same;
`ifdef SEG7_DP_CAPTURE_EN
      same = dig_sel == p_sel && seg_in == p_seg;
`else
      same = dig_sel == p_sel && seg_in[6:0] == p_seg[6:0];
`endif
      run = ($countones(dig_sel) == 1) ? (same ? run + 1 : 1) : 0;
      m_stb = 0;
      if (run == STABLE) begin
        for (int j = 0; j < 4; j++) if (dig_sel[j]) begin
          m_sh[4*j +: 4] = dec(seg_in[6:0]);
          m_sh_err[j] = dec(seg_in[6:0]) == 4'hE;
          m_sh_dp[j] = seg_in[7];
          m_mask[j] = 1;
        end
        if (m_mask == 4'hF) begin
          m_bcd = m_sh; m_err = m_sh_err; m_dp = m_sh_dp;
          m_stb = 1; m_valid = 1; m_mask = 0;
        end
      end
      p_sel = dig_sel;
      p_seg = seg_in;
    end
  end

  // Compare process: DUT against model every cycle, away from the active edge
  always @(negedge clk) if (started) begin
    chk("model_bcd", 32'(bcd_out), 32'(m_bcd));
    chk("model_err", 32'(err), 32'(m_err));
    chk("model_stb", 32'(frame_stb), 32'(m_stb));
    chk("model_valid", 32'(frame_valid), 32'(m_valid));
`ifdef SEG7_DP_CAPTURE_EN
    chk("model_dp", 32'(dp_out), 32'(m_dp));
`endif
    if (frame_stb) stbs++;
  end

  task automatic hold(input logic [3:0] s, input logic [7:0] p, input int n);
    dig_sel = s;
    seg_in = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan4(input logic [7:0] p0, p1, p2, p3);
    hold(4'b0001, p0, 4);
    hold(4'b0010, p1, 4);
    hold(4'b0100, p2, 4);
    hold(4'b1000, p3, 4);
    hold(4'b0000, 8'h00, 2);
  endtask

  initial begin
    rst = 1; dig_sel = 0; seg_in = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bcd", 32'(bcd_out), 32'hFFFF);
    chk("rst_err", 32'(err), 0);
    chk("rst_valid", 32'(frame_valid), 0);
    chk("rst_stb", 32'(frame_stb), 0);
    rst = 0;

    base = stbs;
    scan4(8'h4F, 8'h06, 8'h7F, 8'h6D);
    chk("clean_frames", stbs - base, 1);
    chk("clean_bcd", 32'(bcd_out), 32'h5813);
    chk("clean_err", 32'(err), 0);
    chk("clean_valid", 32'(frame_valid), 1);

    base = stbs;
    hold(4'b0001, 8'h66, 4);
    hold(4'b0010, 8'h5B, 2);
    hold(4'b0100, 8'h07, 4);
    hold(4'b1000, 8'h3F, 4);
    hold(4'b0000, 8'h00, 2);
    chk("glitch_noframe", stbs - base, 0);
    chk("glitch_bcd_kept", 32'(bcd_out), 32'h5813);
    hold(4'b0010, 8'h5B, 3);
    hold(4'b0000, 8'h00, 2);
    chk("glitch_rescan_frames", stbs - base, 1);
    chk("glitch_bcd", 32'(bcd_out), 32'h0724);

    base = stbs;
    scan4(8'h06, 8'h3F, 8'h49, 8'h00);
    chk("inv_frames", stbs - base, 1);
    chk("inv_bcd", 32'(bcd_out), 32'hFE01);
    chk("inv_err", 32'(err), 32'h4);

    base = stbs;
    hold(4'b0001, 8'h6D, 4);
    hold(4'b0010, 8'h7D, 4);
    hold(4'b0100, 8'h07, 4);
    hold(4'b0011, 8'h7F, 6);
    hold(4'b0000, 8'h7F, 3);
    chk("badsel_noframe", stbs - base, 0);
    chk("badsel_bcd_kept", 32'(bcd_out), 32'hFE01);
    hold(4'b1000, 8'h6F, 4);
    hold(4'b0000, 8'h00, 2);
    chk("badsel_frames", stbs - base, 1);
    chk("badsel_bcd", 32'(bcd_out), 32'h9765);
    chk("badsel_err", 32'(err), 0);

    base = stbs;
    hold(4'b0001, 8'h3F, 4);
    hold(4'b0010, 8'h06, 4);
    hold(4'b0100, 8'h5B, 4);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    hold(4'b0000, 8'h00, 3);
    chk("midrst_noframe", stbs - base, 0);
    chk("midrst_valid", 32'(frame_valid), 0);
    chk("midrst_bcd", 32'(bcd_out), 32'hFFFF);
    hold(4'b0001, 8'h06, 2);
    hold(4'b0001, 8'h86, 2);
    hold(4'b0010, 8'h4F, 4);
    hold(4'b0100, 8'h66, 4);
    hold(4'b1000, 8'h7D, 4);
    hold(4'b0000, 8'h00, 2);
`ifndef SEG7_DP_CAPTURE_EN
    chk("midrst_frames", stbs - base, 1);
    chk("midrst_bcd_new", 32'(bcd_out), 32'h6431);
    chk("midrst_valid_new", 32'(frame_valid), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the team's BCD-to-7-segment encoders. It watches a multiplexed, scanned 7-segment display bus (segment pattern plus one-hot digit select) and recovers the displayed digits as BCD. Each pattern is qualified by a stability count, and all digits are presented as one atomic frame. Used for display loopback checking and for reading the panels of external instruments.

## Interface
- DIGITS, 4: number of scanned digits; width of `dig_sel`.
- STABLE_CNT, 3: consecutive identical samples required to accept a digit; legal range 2..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- seg_in  in  8  segment bus; bit order dp,g,f,e,d,c,b,a; 1 = segment lit.
- dig_sel  in  DIGITS  digit select, active-high, must be one-hot; bit i selects digit i.
- bcd_out  out  4*DIGITS  digit i at [4i+3:4i]; 0..9 = decoded, 4'hF = blank, 4'hE = invalid pattern.
- err  out  DIGITS  bit i set when digit i held an invalid pattern in the last frame.
- frame_stb  out  1  one-cycle pulse when a new frame is published.
- frame_valid  out  1  set at first frame; cleared only by reset.
- dp_out  out  DIGITS  decimal point per digit; present only with SEG7_DP_CAPTURE_EN.

## Operation
- Sample registers `s_seg` and `s_sel` capture `seg_in` and `dig_sel` on every edge.
- Match condition: `dig_sel` is one-hot, `dig_sel == s_sel`, and `seg_in[6:0] == s_seg[6:0]`. Bit 7 joins the comparison only with the macro defined.
- Stability counter `cnt`:
  - On match, increments and saturates at STABLE_CNT.
  - Otherwise loads 1 if `dig_sel` is one-hot, else 0.
- Commit: occurs on the edge where match is true and `cnt == STABLE_CNT-1`. Exactly one commit per dwell; a longer dwell does not recommit.
- On commit, the decoded nibble and error bit are written to `shadow[i]`, and `mask[i]` is set.
- Decode of `seg_in[6:0]`:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9.
  - 00→F (blank, not an error).
  - Any other pattern→E with the error bit set.
- Recommitting a digit before the frame completes overwrites its shadow entry; the mask is unchanged.
- Frame completion: when the mask, including the current edge's commit, is all ones:
  - `bcd_out`, `err` (and `dp_out`) are loaded from shadow, including the same-edge commit.
  - `frame_stb` = 1 for that cycle, `frame_valid` = 1, and `mask` clears.
- Non-one-hot `dig_sel` (zero or multiple bits) never commits.
- Reset values: `bcd_out` all 4'hF, `err` 0, `dp_out` 0, `frame_stb` 0, `frame_valid` 0; `cnt`, `mask` and shadow are cleared.
- Reset mid-frame discards partial commits; a full set of DIGITS commits is then required again.

## Timing
- Inputs first presented stable at edge k give `cnt` = 1 at k and commit at edge k+STABLE_CNT-1, i.e. after STABLE_CNT samples.
- Output latency is zero beyond the commit edge: the frame publishes on the edge of the last digit's commit.
- `frame_stb` is registered: high for exactly the cycle following that edge.
- Minimum dwell per digit is STABLE_CNT cycles. A shorter dwell is treated as a glitch and ignored.
- `cnt` width is $clog2(STABLE_CNT+1).

## Configuration
- SEG7_DP_CAPTURE_EN defined:
  - `seg_in[7]` takes part in the match comparison.
  - It is captured per digit into shadow and published on `dp_out` with the frame.
- SEG7_DP_CAPTURE_EN undefined:
  - Bit 7 is ignored entirely; a dp toggle does not break stability.
  - The `dp_out` port and its storage do not exist.

## Structure
- Shared package `seg7_pkg` holds:
  - Pattern constants SEG7_P0..SEG7_P9 in gfedcba order, shared with the encoders.
  - Codes SEG7_BLANK = 4'hF and SEG7_INVALID = 4'hE.
- One sub-module, `seg7_pattern_decode`: combinational, 7-bit pattern in, 4-bit nibble and error bit out, driven from the package constants.
- The top level holds the sample registers, counter, mask, shadow array and output registers.

## Test plan
All scenarios use DIGITS = 4 and STABLE_CNT = 3.
- Reset: assert `rst` for 2 cycles → `bcd_out` = 16'hFFFF, `err` = 0, `frame_valid` = 0, `frame_stb` = 0.
- Clean scan: `dig_sel` 0001/0010/0100/1000 with patterns 4F/06/7F/6D, each held 4 cycles → one `frame_stb` pulse, `bcd_out` = 16'h5813, `err` = 0, `frame_valid` = 1.
- Glitch: digit 1 held only 2 cycles within a scan → no commit, no `frame_stb` until digit 1 is rescanned for 3 or more cycles.
- Invalid and blank: digit 2 = 49, digit 3 = 00, others valid → `bcd_out[11:8]` = E, `err[2]` = 1, `bcd_out[15:12]` = F, `err[3]` = 0.
- Bad select: `dig_sel` = 0011 for 6 cycles, then 0000 → no commit; the mask is unchanged.
- Reset mid-frame: three digits committed, then `rst` pulsed → no frame; a subsequent full 4-digit scan publishes exactly one frame.
